// File: rtl/xor_nibble_sequencer_pkg.sv
// rtl/xor_nibble_sequencer_pkg.sv - shared encodings and helpers for the XOR nibble sequencer
package xor_nibble_sequencer_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_t;

    // The nibble counter needs at least one bit, even when a single step suffices.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/xor_nibble_sequencer_if.sv
// rtl/xor_nibble_sequencer_if.sv - requester and result handshake bundle
interface xor_nibble_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_id;
    logic             busy;

    modport master (
        output req0_valid, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_a, req1_b,
        input  req1_ready,
        input  res_valid, res_data, res_id, busy,
        output res_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_a, req1_b,
        output req1_ready,
        output res_valid, res_data, res_id, busy,
        input  res_ready
    );
endinterface

// File: rtl/xor_nibble_sequencer_ls7486.sv
// rtl/xor_nibble_sequencer_ls7486.sv - model of one quad 2-input XOR TTL slice
import xor_nibble_sequencer_pkg::*;

module ls7486 (
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    output logic [NIB_W-1:0] y
);
    assign y = a ^ b;
endmodule

// File: rtl/xor_nibble_sequencer.sv
// rtl/xor_nibble_sequencer.sv - arbitrates two requesters onto a shared 4-bit XOR slice, one nibble per clock
import xor_nibble_sequencer_pkg::*;

module xor_nibble_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    xor_nibble_sequencer_if.slave bus
);
    localparam int N     = WIDTH / NIB_W;
    localparam int CNT_W = cnt_width(N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    state_t           state;
    req_id_t          last_grant;
    req_id_t          winner;
    req_id_t          id_q;
    logic             accept;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             res_valid_q;
    logic             busy_q;
    logic [NIB_W-1:0] a_nib;
    logic [NIB_W-1:0] b_nib;
    logic [NIB_W-1:0] y_nib;

    // Requester 1 wins when it is alone or when requester 0 had the previous grant.
    always_comb begin
        winner = REQ0;
        if (bus.req1_valid && (!bus.req0_valid || last_grant == REQ0))
            winner = REQ1;
    end

    assign accept         = (state == IDLE) && (bus.req0_valid || bus.req1_valid);
    assign bus.req0_ready = accept && (winner == REQ0);
    assign bus.req1_ready = accept && (winner == REQ1);

    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < N; i++) begin
            if (cnt == CNT_W'(i)) begin
                a_nib = a_q[i*NIB_W +: NIB_W];
                b_nib = b_q[i*NIB_W +: NIB_W];
            end
        end
    end

    ls7486 u_xor (
        .a (a_nib),
        .b (b_nib),
        .y (y_nib)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_grant  <= REQ1;
            id_q        <= REQ0;
            cnt         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q        <= (winner == REQ1) ? bus.req1_a : bus.req0_a;
                        b_q        <= (winner == REQ1) ? bus.req1_b : bus.req0_b;
                        id_q       <= winner;
                        last_grant <= winner;
                        cnt        <= '0;
                        busy_q     <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < N; i++) begin
                        if (cnt == CNT_W'(i))
                            res_q[i*NIB_W +: NIB_W] <= y_nib;
                    end
                    // The counter parks on the last nibble instead of wrapping.
                    if (cnt == CNT_LAST) begin
                        res_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_q;
    assign bus.res_id    = id_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_xor_nibble_sequencer.sv
// tb/tb_xor_nibble_sequencer.sv - scoreboard bench for the XOR nibble sequencer at WIDTH 16 and 8
module tb_xor_nibble_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    xor_nibble_sequencer_if #(.WIDTH(16)) bus16 ();
    xor_nibble_sequencer_if #(.WIDTH(8))  bus8 ();

    xor_nibble_sequencer #(.WIDTH(16)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16)
    );

    xor_nibble_sequencer #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    typedef struct {
        logic        id;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 60) begin
            tick();
            k++;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        sb.delete();
    endtask

    // Expected results enter at accept and leave at the result handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (bus16.res_valid && bus16.res_ready) begin
                if (sb.size() == 0) begin
                    check("result_without_request", bus16.res_valid, 0);
                end else begin
                    e = sb.pop_front();
                    check("res_data", bus16.res_data, e.data);
                    check("res_id", bus16.res_id, e.id);
                end
            end
            if (bus16.req0_ready) sb.push_back('{1'b0, bus16.req0_a ^ bus16.req0_b});
            if (bus16.req1_ready) sb.push_back('{1'b1, bus16.req1_a ^ bus16.req1_b});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          n;
        int          got;
        logic        w0;
        logic        w1;
        logic [15:0] ea;
        logic [15:0] eb;

        bus16.req0_valid = 0; bus16.req0_a = '0; bus16.req0_b = '0;
        bus16.req1_valid = 0; bus16.req1_a = '0; bus16.req1_b = '0;
        bus16.res_ready  = 1;
        bus8.req0_valid  = 0; bus8.req0_a = '0; bus8.req0_b = '0;
        bus8.req1_valid  = 0; bus8.req1_a = '0; bus8.req1_b = '0;
        bus8.res_ready   = 1;

        repeat (2) @(negedge clk);
        check("rst_res_valid", bus16.res_valid, 0);
        check("rst_busy", bus16.busy, 0);
        check("rst_res_data", bus16.res_data, 0);
        check("rst_res_id", bus16.res_id, 0);
        check("rst_res_valid8", bus8.res_valid, 0);
        tick();
        rst_n = 1'b1;

        // Single request
        tick();
        bus16.req0_valid = 1; bus16.req0_a = 16'hA5F0; bus16.req0_b = 16'h5AFF;
        @(negedge clk);
        check("single_ready0", bus16.req0_ready, 1);
        check("single_ready1", bus16.req1_ready, 0);
        tick();
        bus16.req0_valid = 0; bus16.req0_a = '0; bus16.req0_b = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("single_busy", bus16.busy, 1);
            check("single_res_valid", bus16.res_valid, (i == 4));
            if (i == 4) check("single_data", bus16.res_data, 16'hFF0F);
            tick();
        end
        @(negedge clk);
        check("single_busy_end", bus16.busy, 0);
        check("single_valid_end", bus16.res_valid, 0);
        drain();

        // Contention right after reset: requester 0 first
        do_reset();
        bus16.req0_valid = 1; bus16.req0_a = 16'h1234; bus16.req0_b = 16'h00FF;
        bus16.req1_valid = 1; bus16.req1_a = 16'hFFFF; bus16.req1_b = 16'h0F0F;
        @(negedge clk);
        check("cont_ready0", bus16.req0_ready, 1);
        check("cont_ready1", bus16.req1_ready, 0);
        tick();
        bus16.req0_valid = 0;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (bus16.req1_ready) break;
            tick();
            n++;
        end
        check("cont_req1_accept_edge", n + 1, 6);
        tick();
        bus16.req1_valid = 0;
        drain();

        // Fairness with both requesters continuously valid
        bus16.req0_valid = 1; bus16.req0_a = 16'($urandom); bus16.req0_b = 16'($urandom);
        bus16.req1_valid = 1; bus16.req1_a = 16'($urandom); bus16.req1_b = 16'($urandom);
        got = 0;
        n = 0;
        while (got < 4 && n < 100) begin
            @(negedge clk);
            w0 = bus16.req0_ready;
            w1 = bus16.req1_ready;
            if (w0 || w1) begin
                check("fair_winner", w1, got % 2);
                got++;
            end
            tick();
            n++;
            if (w0) begin bus16.req0_a = 16'($urandom); bus16.req0_b = 16'($urandom); end
            if (w1) begin bus16.req1_a = 16'($urandom); bus16.req1_b = 16'($urandom); end
        end
        check("fair_count", got, 4);
        bus16.req0_valid = 0;
        bus16.req1_valid = 0;
        drain();

        // Result backpressure
        bus16.res_ready = 0;
        ea = 16'($urandom); eb = 16'($urandom);
        bus16.req0_valid = 1; bus16.req0_a = ea; bus16.req0_b = eb;
        @(negedge clk);
        check("bp_ready0", bus16.req0_ready, 1);
        tick();
        bus16.req0_valid = 0;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (bus16.res_valid) break;
            tick();
            n++;
        end
        check("bp_res_valid_seen", bus16.res_valid, 1);
        bus16.req1_valid = 1; bus16.req1_a = 16'h0F0F; bus16.req1_b = 16'h3333;
        for (int i = 0; i < 5; i++) begin
            if (i != 0) @(negedge clk);
            check("bp_hold_valid", bus16.res_valid, 1);
            check("bp_hold_data", bus16.res_data, ea ^ eb);
            check("bp_hold_id", bus16.res_id, 0);
            check("bp_hold_ready0", bus16.req0_ready, 0);
            check("bp_hold_ready1", bus16.req1_ready, 0);
            tick();
        end
        bus16.res_ready = 1;
        tick();
        @(negedge clk);
        check("bp_idle_busy", bus16.busy, 0);
        check("bp_idle_valid", bus16.res_valid, 0);
        tick();
        bus16.req1_valid = 0;
        drain();

        // Reset in the middle of a run
        bus16.req1_valid = 1; bus16.req1_a = 16'hBEEF; bus16.req1_b = 16'h1357;
        @(negedge clk);
        check("mid_ready1", bus16.req1_ready, 1);
        tick();
        bus16.req1_valid = 0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", bus16.busy, 0);
        check("mid_rst_valid", bus16.res_valid, 0);
        check("mid_rst_data", bus16.res_data, 0);
        check("mid_rst_id", bus16.res_id, 0);
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("mid_no_result", bus16.res_valid, 0);
            tick();
        end
        bus16.req0_valid = 1; bus16.req0_a = 16'h0001; bus16.req0_b = 16'hF00F;
        @(negedge clk);
        check("post_rst_ready0", bus16.req0_ready, 1);
        tick();
        bus16.req0_valid = 0;
        drain();

        // WIDTH=8 instance
        bus8.req0_valid = 1; bus8.req0_a = 8'hC3; bus8.req0_b = 8'h3C;
        @(negedge clk);
        check("w8_ready0", bus8.req0_ready, 1);
        tick();
        bus8.req0_valid = 0;
        @(negedge clk);
        check("w8_valid_e0", bus8.res_valid, 0);
        tick();
        @(negedge clk);
        check("w8_valid_e1", bus8.res_valid, 0);
        tick();
        @(negedge clk);
        check("w8_valid_e2", bus8.res_valid, 1);
        check("w8_data", bus8.res_data, 8'hFF);
        check("w8_id", bus8.res_id, 0);
        tick();
        @(negedge clk);
        check("w8_busy_end", bus8.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
